game_board_input: RTL and testbench
===================================

Name: game_board_input

Overview:
- Inverse path of the board renderer: turns the player's pointer position, clicks and key strokes into cell selections and board write commands.
- Maps the mouse pixel position onto the centred N²×N² sudoku grid (16×16 px cells) and latches the selected cell.
- Issues a one-cycle write (row, col, value) to the board storage when a legal digit key arrives while a cell is selected.
- Sits between the mouse/keyboard front-ends and the board register array.

Parameters:
- SCREEN_WIDTH, 1024, active horizontal pixels
- SCREEN_HEIGHT, 768, active vertical pixels
- CELL_PX, 16, cell edge length in pixels (power of two; shift-based division)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-low reset
- is_game_on  in  1  game active; low forces deselect and blocks writes
- board_size  in  3  N (box size); legal 2..4, grid is N²×N² cells
- mouse_x  in  12  pointer x, pixel units
- mouse_y  in  12  pointer y, pixel units
- mouse_left  in  1  left button level (already synchronised)
- key_valid  in  1  one-cycle strobe, key_value valid
- key_value  in  5  0 = clear cell, 1..N² = digit
- sel_valid  out  1  a cell is currently selected
- sel_row  out  4  selected row, 0 = top
- sel_col  out  4  selected column, 0 = left
- wr_en  out  1  one-cycle board write strobe
- wr_row  out  4  write row
- wr_col  out  4  write column
- wr_value  out  5  value to store

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0
  - input registers cleared; FSM in IDLE
- Geometry, combinational from board_size N:
  - span = CELL_PX·N·N
  - X0 = (SCREEN_WIDTH−span)>>1, Y0 = (SCREEN_HEIGHT−span)>>1
  - all arithmetic 16-bit unsigned
- Inside test: X0 ≤ x < X0+span and Y0 ≤ y < Y0+span. Then col = (x−X0)>>4, row = (y−Y0)>>4.
- Stage 1: mouse_x, mouse_y, mouse_left registered every cycle.
- Click event: the registered mouse_left is 1 and its previous registered value is 0.
  - A button held high generates exactly one event.
- Latency: mouse_left first sampled high at edge k → sel_* valid after edge k+2.
- FSM states:
  - IDLE: sel_valid=0.
    - Click inside → SELECTED, latch row/col.
    - Click outside → stay IDLE.
  - SELECTED: sel_valid=1.
    - Click inside → relatch row/col.
    - Click outside → IDLE.
    - Legal key → WRITE.
  - WRITE: wr_en=1 for exactly one cycle with wr_row/wr_col = latched selection and wr_value = key_value captured in SELECTED. Then → SELECTED unconditionally.
    - Click events arriving in WRITE are queued one deep and processed in the following SELECTED cycle.
    - key_valid arriving in WRITE is dropped.
- Legal key: key_valid=1 and key_value ≤ N·N. Any other value is ignored; no state change.
- Simultaneous click event and key_valid in SELECTED: the click is processed and the key is dropped.
- is_game_on=0, or board_size ∉ {2,3,4}:
  - next edge → IDLE, wr_en=0, sel_valid=0
  - clicks and keys ignored
  - the pending queued click is discarded
- wr_row/wr_col/wr_value hold their last values when wr_en=0. Only the wr_en pulse is meaningful.
- Mouse coordinates beyond the screen are simply outside; no wrap-around.

Test Plan:
- N=3 (span 144, X0=440, Y0=312): click at (509,424) → sel_valid=1, sel_col=4, sel_row=7 two edges after press.
- Boundaries, N=4 (X0=384, Y0=256):
  - click (384,256) → row 0, col 0
  - click (639,511) → row 15, col 15
  - click (640,300) → sel_valid=0
  - click (383,300) → sel_valid=0
- N=2 (X0=480, Y0=352): select (row 1, col 2), then key_value=4 → single wr_en pulse with wr_row=1, wr_col=2, wr_value=4. Then key_value=5 → no wr_en.
- Hold mouse_left high for 100 cycles → one selection update only. Key strobe in the same cycle as a new click → no write, selection moves.
- Drop is_game_on mid-selection → sel_valid=0 on next edge; subsequent keys produce no writes. Assert rst=0 asynchronously mid-WRITE → wr_en and sel_valid fall immediately, without waiting for a clock edge.
- board_size=5 with clicks and keys applied → all outputs remain 0.

Source files
------------

// File: rtl/game_board_input.sv
// Converts the pointer position, clicks and key strokes into sudoku cell
// selections and one-cycle board write commands for a centred N^2 x N^2 grid.
module game_board_input #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 768,
  parameter int CELL_PX       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_game_on,
  input  logic [2:0]  board_size,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_left,
  input  logic        key_valid,
  input  logic [4:0]  key_value,
  output logic        sel_valid,
  output logic [3:0]  sel_row,
  output logic [3:0]  sel_col,
  output logic        wr_en,
  output logic [3:0]  wr_row,
  output logic [3:0]  wr_col,
  output logic [4:0]  wr_value
);

  localparam int          SHIFT = $clog2(CELL_PX);
  localparam logic [15:0] SW    = 16'(SCREEN_WIDTH);
  localparam logic [15:0] SH    = 16'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] mx_q, mx_d, my_q, my_d;
  logic        left_q, left_d, left_prev_q, left_prev_d;
  logic        click_q, click_d, inside_q, inside_d;
  logic [3:0]  row_q, row_d, col_q, col_d;
  logic        pend_q, pend_d, pend_inside_q, pend_inside_d;
  logic [3:0]  pend_row_q, pend_row_d, pend_col_q, pend_col_d;
  logic [3:0]  sel_row_q, sel_row_d, sel_col_q, sel_col_d;
  logic [3:0]  wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [4:0]  wr_value_q, wr_value_d;

  logic [15:0] n_s, nn_s, span_s, x0_s, y0_s, mx_s, my_s, dx_s, dy_s;
  logic        inside_s, size_ok_s, enable_s, key_legal_s;

  assign n_s       = {13'd0, board_size};
  assign nn_s      = n_s * n_s;
  assign span_s    = nn_s << SHIFT;
  assign x0_s      = (SW - span_s) >> 1;
  assign y0_s      = (SH - span_s) >> 1;
  assign mx_s      = {4'd0, mx_q};
  assign my_s      = {4'd0, my_q};
  assign dx_s      = mx_s - x0_s;
  assign dy_s      = my_s - y0_s;
  assign inside_s  = (mx_s >= x0_s) && (mx_s < (x0_s + span_s)) &&
                     (my_s >= y0_s) && (my_s < (y0_s + span_s));
  assign size_ok_s = (board_size >= 3'd2) && (board_size <= 3'd4);
  assign enable_s  = is_game_on && size_ok_s;
  // Digit 0 clears a cell, so the legal range is 0..N*N inclusive.
  assign key_legal_s = key_valid && ({11'd0, key_value} <= nn_s);

  // Input sampling stage and the hit-test stage behind it.
  always_comb begin
    mx_d        = mouse_x;
    my_d        = mouse_y;
    left_d      = mouse_left;
    left_prev_d = left_q;
    click_d     = left_q && !left_prev_q;
    inside_d    = inside_s;
    row_d       = 4'(dy_s >> SHIFT);
    col_d       = 4'(dx_s >> SHIFT);
  end

  // Selection/write FSM next-state logic.
  always_comb begin
    state_d       = state_q;
    sel_row_d     = sel_row_q;
    sel_col_d     = sel_col_q;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    wr_value_d    = wr_value_q;
    pend_d        = pend_q;
    pend_inside_d = pend_inside_q;
    pend_row_d    = pend_row_q;
    pend_col_d    = pend_col_q;
    if (!enable_s) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_d = 1'b0;
          if (click_q && inside_q) begin
            state_d   = SELECTED;
            sel_row_d = row_q;
            sel_col_d = col_q;
          end else begin
            state_d = IDLE;
          end
        end
        SELECTED: begin
          // A click queued during WRITE takes precedence; any key is dropped.
          if (pend_q) begin
            pend_d = 1'b0;
            if (pend_inside_q) begin
              sel_row_d = pend_row_q;
              sel_col_d = pend_col_q;
            end else begin
              state_d = IDLE;
            end
          end else if (click_q) begin
            if (inside_q) begin
              sel_row_d = row_q;
              sel_col_d = col_q;
            end else begin
              state_d = IDLE;
            end
          end else if (key_legal_s) begin
            state_d    = WRITE;
            wr_row_d   = sel_row_q;
            wr_col_d   = sel_col_q;
            wr_value_d = key_value;
          end else begin
            state_d = SELECTED;
          end
        end
        WRITE: begin
          state_d = SELECTED;
          if (click_q) begin
            pend_d        = 1'b1;
            pend_inside_d = inside_q;
            pend_row_d    = row_q;
            pend_col_d    = col_q;
          end else begin
            pend_d = pend_q;
          end
        end
        default: begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // Input pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mx_q        <= 12'd0;
      my_q        <= 12'd0;
      left_q      <= 1'b0;
      left_prev_q <= 1'b0;
      click_q     <= 1'b0;
      inside_q    <= 1'b0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
    end else begin
      mx_q        <= mx_d;
      my_q        <= my_d;
      left_q      <= left_d;
      left_prev_q <= left_prev_d;
      click_q     <= click_d;
      inside_q    <= inside_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  // FSM state, selection, pending click and write command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sel_row_q     <= 4'd0;
      sel_col_q     <= 4'd0;
      wr_row_q      <= 4'd0;
      wr_col_q      <= 4'd0;
      wr_value_q    <= 5'd0;
      pend_q        <= 1'b0;
      pend_inside_q <= 1'b0;
      pend_row_q    <= 4'd0;
      pend_col_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      sel_row_q     <= sel_row_d;
      sel_col_q     <= sel_col_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_value_q    <= wr_value_d;
      pend_q        <= pend_d;
      pend_inside_q <= pend_inside_d;
      pend_row_q    <= pend_row_d;
      pend_col_q    <= pend_col_d;
    end
  end

  assign sel_valid = (state_q != IDLE);
  assign sel_row   = sel_row_q;
  assign sel_col   = sel_col_q;
  assign wr_en     = (state_q == WRITE);
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_value  = wr_value_q;

endmodule

// File: tb/tb_game_board_input.sv
// Self-checking bench for game_board_input: click vector table plus
// hand-written key/write, hold, pending-click, disable and reset sequences.
module tb_game_board_input;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_game_on = 1'b1;
  logic [2:0]  board_size = 3'd3;
  logic [11:0] mouse_x = 12'd0, mouse_y = 12'd0;
  logic        mouse_left = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_value = 5'd0;
  logic        sel_valid, wr_en;
  logic [3:0]  sel_row, sel_col, wr_row, wr_col;
  logic [4:0]  wr_value;

  game_board_input dut (
    .clk(clk), .rst(rst_n), .is_game_on(is_game_on), .board_size(board_size),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .key_valid(key_valid), .key_value(key_value),
    .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_value(wr_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  n;
    logic [11:0] x;
    logic [11:0] y;
    logic        v;
    logic [3:0]  r;
    logic [3:0]  c;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] r;
    logic [3:0] c;
  } sel_t;

  typedef struct {
    logic [3:0] r;
    logic [3:0] c;
    logic [4:0] val;
  } wr_t;

  sel_t exp_sel_q[$];
  wr_t  exp_wr_q[$];
  wr_t  obs_wr_q[$];
  vec_t vecs[$];

  int n_vec = 0;
  int n_miss = 0;
  logic       m_v = 1'b0;
  logic [3:0] m_r = 4'd0, m_c = 4'd0;

  // Collect every write pulse the DUT issues.
  always @(negedge clk) begin
    if (rst_n && wr_en) obs_wr_q.push_back('{wr_row, wr_col, wr_value});
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string nm, input sel_t e);
    chk({nm, ".valid"}, 32'(sel_valid), 32'(e.v));
    if (e.v) begin
      chk({nm, ".row"}, 32'(sel_row), 32'(e.r));
      chk({nm, ".col"}, 32'(sel_col), 32'(e.c));
    end
  endtask

  task automatic model_update(input logic v, input logic [3:0] r, input logic [3:0] c);
    m_v = v;
    if (v) begin
      m_r = r;
      m_c = c;
    end
  endtask

  // One-cycle press; selection must be unchanged after k+1 and updated after k+2.
  task automatic click(input string nm, input logic [11:0] x, input logic [11:0] y,
                       input logic v, input logic [3:0] r, input logic [3:0] c);
    sel_t e;
    mouse_x = x; mouse_y = y; mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
    chk_sel({nm, ".early"}, '{m_v, m_r, m_c});
    exp_sel_q.push_back('{v, r, c});
    step();
    e = exp_sel_q.pop_front();
    chk_sel(nm, e);
    model_update(v, r, c);
  endtask

  task automatic press_key(input logic [4:0] val, input logic expect_wr);
    key_valid = 1'b1; key_value = val;
    if (expect_wr) exp_wr_q.push_back('{m_r, m_c, val});
    step();
    key_valid = 1'b0;
    step();
    step();
  endtask

  task automatic compare_writes(input string nm);
    wr_t e, o;
    chk({nm, ".count"}, 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      chk({nm, ".row"}, 32'(o.r), 32'(e.r));
      chk({nm, ".col"}, 32'(o.c), 32'(e.c));
      chk({nm, ".value"}, 32'(o.val), 32'(e.val));
    end
    exp_wr_q.delete();
    obs_wr_q.delete();
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({sel_valid, sel_row, sel_col, wr_en, wr_row, wr_col, wr_value}), 32'd0);
  endtask

  initial begin
    vecs.push_back('{3'd3, 12'd509,  12'd424,  1'b1, 4'd7,  4'd4});
    vecs.push_back('{3'd4, 12'd384,  12'd256,  1'b1, 4'd0,  4'd0});
    vecs.push_back('{3'd4, 12'd639,  12'd511,  1'b1, 4'd15, 4'd15});
    vecs.push_back('{3'd4, 12'd640,  12'd300,  1'b0, 4'd0,  4'd0});
    vecs.push_back('{3'd4, 12'd400,  12'd270,  1'b1, 4'd0,  4'd1});
    vecs.push_back('{3'd4, 12'd383,  12'd300,  1'b0, 4'd0,  4'd0});
    vecs.push_back('{3'd2, 12'd543,  12'd415,  1'b1, 4'd3,  4'd3});
    vecs.push_back('{3'd2, 12'd4000, 12'd4000, 1'b0, 4'd0,  4'd0});
    vecs.push_back('{3'd2, 12'd517,  12'd371,  1'b1, 4'd1,  4'd2});

    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      board_size = vecs[i].n;
      click($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].r, vecs[i].c);
    end

    // N=2 writes: 4 and 0 are legal, 5 exceeds N*N.
    press_key(5'd4, 1'b1);
    press_key(5'd5, 1'b0);
    press_key(5'd0, 1'b1);
    compare_writes("wr_n2");

    // Click arriving while WRITE is active is queued and applied afterwards.
    mouse_x = 12'd543; mouse_y = 12'd415; mouse_left = 1'b1;
    step();
    mouse_left = 1'b0; key_valid = 1'b1; key_value = 5'd2;
    exp_wr_q.push_back('{m_r, m_c, 5'd2});
    step();
    key_valid = 1'b0;
    step();
    chk_sel("pend.before", '{m_v, m_r, m_c});
    step();
    model_update(1'b1, 4'd3, 4'd3);
    chk_sel("pend.after", '{m_v, m_r, m_c});
    step();
    compare_writes("wr_pend");

    // Key in the same cycle as a click event: selection moves, no write.
    mouse_x = 12'd481; mouse_y = 12'd353; mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
    key_valid = 1'b1; key_value = 5'd1;
    step();
    key_valid = 1'b0;
    model_update(1'b1, 4'd0, 4'd0);
    chk_sel("simul", '{m_v, m_r, m_c});
    step();
    step();
    compare_writes("wr_simul");

    // Held button yields a single selection update.
    mouse_x = 12'd517; mouse_y = 12'd371; mouse_left = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        mouse_x = 12'd543; mouse_y = 12'd415;
      end
      step();
    end
    model_update(1'b1, 4'd1, 4'd2);
    chk_sel("hold", '{m_v, m_r, m_c});
    mouse_left = 1'b0;
    step(); step(); step();
    chk_sel("hold.release", '{m_v, m_r, m_c});

    // Game off deselects on the next edge and blocks writes.
    is_game_on = 1'b0;
    step();
    model_update(1'b0, 4'd0, 4'd0);
    chk_sel("game_off", '{m_v, m_r, m_c});
    press_key(5'd1, 1'b0);
    is_game_on = 1'b1;
    step();
    chk_sel("game_on_idle", '{m_v, m_r, m_c});
    press_key(5'd2, 1'b0);
    compare_writes("wr_game_off");

    // Asynchronous reset while WRITE is active.
    click("rst_sel", 12'd517, 12'd371, 1'b1, 4'd1, 4'd2);
    key_valid = 1'b1; key_value = 5'd3;
    step();
    key_valid = 1'b0;
    chk("rst.wr_en_before", 32'(wr_en), 32'd1);
    chk("rst.wr_value_before", 32'(wr_value), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.wr_en_async", 32'(wr_en), 32'd0);
    chk("rst.sel_valid_async", 32'(sel_valid), 32'd0);
    chk_all_zero("rst.all_async");
    #3 rst_n = 1'b1;
    model_update(1'b0, 4'd0, 4'd0);
    step();
    compare_writes("wr_rst");

    // Illegal board size: nothing ever leaves reset values.
    board_size = 3'd5;
    click("size5", 12'd509, 12'd424, 1'b0, 4'd0, 4'd0);
    press_key(5'd1, 1'b0);
    press_key(5'd3, 1'b0);
    chk_all_zero("size5.all");
    click("size5b", 12'd512, 12'd384, 1'b0, 4'd0, 4'd0);
    chk_all_zero("size5b.all");
    compare_writes("wr_size5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
